// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Decodes the immediate field of a raw RV32 instruction word and delivers
//   it through a registered, two-entry skid buffer with valid/ready
//   handshakes on both sides. A 16-bit saturating counter tracks completed
//   output handshakes.
//
// Ports
//   clk, rst_n         single clock, synchronous active-low reset
//   in_valid/in_ready  upstream handshake; in_instr + in_tag are the payload
//   out_valid/out_ready downstream handshake
//   out_imm            XLEN-bit extended immediate
//   out_fmt            0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
//   out_illegal        opcode not recognised
//   out_tag            tag travelling with the entry on out_imm
//   clr_count          synchronous clear of out_count (wins over increment)
//   out_count          saturating count of output handshakes
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  input  logic             clr_count,
  output logic [15:0]      out_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Every signed format is first assembled as a 32-bit signed value and then
  // widened by a signed cast, so XLEN=64 sign-extends from instr[31] for all
  // of them (U included). zimm is the only zero-extended field.
  function automatic entry_t decode(input logic [31:0] i, input logic [TAG_W-1:0] t);
    entry_t             e;
    logic signed [31:0] s32;
    e.tag = t;
    e.ill = 1'b0;
    e.fmt = FMT_NONE;
    e.imm = '0;
    s32   = '0;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        e.fmt = FMT_I;
        s32   = {{20{i[31]}}, i[31:20]};
      end
      7'b0100011: begin
        e.fmt = FMT_S;
        s32   = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'b1100011: begin
        e.fmt = FMT_B;
        s32   = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'b0010111, 7'b0110111: begin
        e.fmt = FMT_U;
        s32   = {i[31:12], 12'b0};
      end
      7'b1101111: begin
        e.fmt = FMT_J;
        s32   = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'b1110011: e.fmt = FMT_Z;
      default:    e.ill = 1'b1;
    endcase
    if (e.fmt == FMT_Z) e.imm = XLEN'({27'b0, i[19:15]});
    else                e.imm = XLEN'(s32);
    return e;
  endfunction

  state_t      state_q, state_d;
  entry_t      out_q, out_d;
  entry_t      skid_q, skid_d;
  logic [15:0] cnt_q, cnt_d;
  entry_t      dec;
  logic        acc, deq;

  assign in_ready    = rst_n && (state_q != ST_TWO);
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.ill;
  assign out_tag     = out_q.tag;
  assign out_count   = cnt_q;

  always_comb begin
    dec     = decode(in_instr, in_tag);
    acc     = in_valid && in_ready;
    deq     = out_valid && out_ready;
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          out_d   = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && !deq) begin
          skid_d  = dec;
          state_d = ST_TWO;
        end else if (!acc && deq) begin
          state_d = ST_EMPTY;
        end else if (acc && deq) begin
          out_d   = dec;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (deq) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (clr_count)                  cnt_d = '0;
    else if (deq && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    else                            cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  // Skid contents are only observable after a move to ST_TWO, so they need
  // no reset value.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, out_ready, clr_count;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0]      out_imm_a;
  logic [2:0]       out_fmt_a;
  logic [TAG_W-1:0] out_tag_a;
  logic [15:0]      out_count_a;

  logic             in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0]      out_imm_b;
  logic [2:0]       out_fmt_b;
  logic [TAG_W-1:0] out_tag_b;
  logic [15:0]      out_count_b;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_imm(out_imm_a), .out_fmt(out_fmt_a),
    .out_illegal(out_illegal_a), .out_tag(out_tag_a), .clr_count(clr_count),
    .out_count(out_count_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_imm(out_imm_b), .out_fmt(out_fmt_b),
    .out_illegal(out_illegal_b), .out_tag(out_tag_b), .clr_count(clr_count),
    .out_count(out_count_b)
  );

  typedef struct {
    logic [63:0]      imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  exp_t sbq[$];
  exp_t cur_exp;
  int   checks = 0;
  int   errors = 0;
  bit   rnd_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference decoder: builds each immediate from a replicated sign word and
  // shifted instruction fields in 64 bits; XLEN=32 uses the low half.
  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t        e;
    logic [63:0] hi;
    hi    = i[31] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
    e.imm = 64'h0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    e.tag = '0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin e.fmt = 3'd1; e.imm = (hi << 12) | 64'(i[31:20]); end
      7'h23: begin e.fmt = 3'd2; e.imm = (hi << 12) | (64'(i[31:25]) << 5) | 64'(i[11:7]); end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = (hi << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
      end
      7'h17, 7'h37: begin e.fmt = 3'd4; e.imm = (hi << 32) | (64'(i[31:12]) << 12); end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = (hi << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
      end
      7'h73: begin e.fmt = 3'd6; e.imm = 64'(i[19:15]); end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard: pop/compare on output handshakes, push on input accepts,
  // flush on reset edges, and check hold-stability while stalled.
  logic [63:0]      snap_imm;
  logic [2:0]       snap_fmt;
  logic             snap_ill;
  logic [TAG_W-1:0] snap_tag;
  bit               prev_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid_a), 64'd1);
        chk("stall_imm", out_imm_b, snap_imm);
        chk("stall_fmt", 64'(out_fmt_a), 64'(snap_fmt));
        chk("stall_ill", 64'(out_illegal_a), 64'(snap_ill));
        chk("stall_tag", 64'(out_tag_a), 64'(snap_tag));
      end
      if (out_valid_a && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %0h imm %0h expected no entry", out_tag_a, out_imm_a);
        end else begin
          e = sbq.pop_front();
          chk("imm32", 64'(out_imm_a), 64'(e.imm[31:0]));
          chk("imm64", out_imm_b, e.imm);
          chk("fmt32", 64'(out_fmt_a), 64'(e.fmt));
          chk("fmt64", 64'(out_fmt_b), 64'(e.fmt));
          chk("ill32", 64'(out_illegal_a), 64'(e.ill));
          chk("ill64", 64'(out_illegal_b), 64'(e.ill));
          chk("tag32", 64'(out_tag_a), 64'(e.tag));
          chk("tag64", 64'(out_tag_b), 64'(e.tag));
        end
      end
      if (in_valid && in_ready_a) sbq.push_back(cur_exp);
      prev_stall = out_valid_a && !out_ready;
      snap_imm   = out_imm_b;
      snap_fmt   = out_fmt_a;
      snap_ill   = out_illegal_a;
      snap_tag   = out_tag_a;
    end
  end

  task automatic send(input logic [31:0] ins, input logic [TAG_W-1:0] tg, input exp_t e, output int waits);
    bit done;
    done     = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tg;
    cur_exp  = e;
    cur_exp.tag = tg;
    while (!done && waits < 100) begin
      @(negedge clk);
      done = in_ready_a;
      @(posedge clk);
      #1;
      if (!done) begin
        waits++;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept for tag %0h expected accept within 100 cycles", tg);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  vec_t        vecs[13];
  logic [6:0]  ops[10];
  int          w, tot;
  logic [31:0] r;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
    vecs[3]  = '{32'h000F2073, 64'h0000_0000_0000_001E, 3'd6, 1'b0};
    vecs[4]  = '{32'h00F02073, 64'h0000_0000_0000_0000, 3'd6, 1'b0};
    vecs[5]  = '{32'h0000007F, 64'h0000_0000_0000_0000, 3'd0, 1'b1};
    vecs[6]  = '{32'h00112623, 64'h0000_0000_0000_000C, 3'd2, 1'b0};
    vecs[7]  = '{32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0};
    vecs[8]  = '{32'h00001097, 64'h0000_0000_0000_1000, 3'd4, 1'b0};
    vecs[9]  = '{32'h7FF12083, 64'h0000_0000_0000_07FF, 3'd1, 1'b0};
    vecs[10] = '{32'h80008067, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0};
    vecs[11] = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};
    vecs[12] = '{32'h002081B3, 64'h0000_0000_0000_0000, 3'd0, 1'b1};
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F, 7'h73, 7'h00};

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0;
    out_ready = 1'b1; clr_count = 1'b0;
    cur_exp = '{64'h0, 3'd0, 1'b0, '0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_low", 64'(in_ready_a), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_out_imm32", 64'(out_imm_a), 64'd0);
    chk("rst_out_imm64", out_imm_b, 64'd0);
    chk("rst_out_fmt", 64'(out_fmt_a), 64'd0);
    chk("rst_out_ill", 64'(out_illegal_a), 64'd0);
    chk("rst_out_tag", 64'(out_tag_a), 64'd0);
    chk("rst_out_count", 64'(out_count_a), 64'd0);
    chk("rst_in_ready_high", 64'(in_ready_a), 64'd1);

    // single accept: one-cycle latency
    @(posedge clk); #1;
    send(vecs[0].instr, 5'd7, '{vecs[0].imm, vecs[0].fmt, vecs[0].ill, '0}, w);
    @(negedge clk);
    chk("latency_valid", 64'(out_valid_a), 64'd1);
    chk("latency_imm", 64'(out_imm_a), 64'hFFFF_FFFF);
    drain();

    // table, back-to-back at full rate
    @(posedge clk); #1;
    tot = 0;
    for (int k = 0; k < 13; k++) begin
      send(vecs[k].instr, TAG_W'(k), '{vecs[k].imm, vecs[k].fmt, vecs[k].ill, '0}, w);
      tot += w;
    end
    chk("throughput_stalls", 64'(tot), 64'd0);
    drain();
    @(negedge clk);
    chk("count_after_table", 64'(out_count_a), 64'd14);
    chk("count_after_table64", 64'(out_count_b), 64'd14);

    // clear coinciding with a handshake
    @(posedge clk); #1;
    send(vecs[9].instr, 5'd20, ref_dec(vecs[9].instr), w);
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    @(negedge clk);
    chk("clr_priority", 64'(out_count_a), 64'd0);
    @(posedge clk); #1;
    send(vecs[6].instr, 5'd21, ref_dec(vecs[6].instr), w);
    drain();
    @(negedge clk);
    chk("count_after_clr", 64'(out_count_a), 64'd1);

    // stall: fill both entries, third offer is refused, then release
    @(posedge clk); #1;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    out_ready = 1'b0;
    send(vecs[1].instr, 5'd1, ref_dec(vecs[1].instr), w);
    send(vecs[2].instr, 5'd2, ref_dec(vecs[2].instr), w);
    in_valid = 1'b1; in_instr = vecs[3].instr; in_tag = 5'd3;
    cur_exp = ref_dec(vecs[3].instr); cur_exp.tag = 5'd3;
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready_a), 64'd0);
    chk("full_out_valid", 64'(out_valid_a), 64'd1);
    chk("full_out_tag", 64'(out_tag_a), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_in_ready2", 64'(in_ready_a), 64'd0);
    chk("full_out_tag2", 64'(out_tag_a), 64'd1);
    out_ready = 1'b1;
    send(vecs[3].instr, 5'd3, ref_dec(vecs[3].instr), w);
    drain();
    @(negedge clk);
    chk("count_after_stall", 64'(out_count_a), 64'd3);

    // reset while both entries are full
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(vecs[7].instr, 5'd9, ref_dec(vecs[7].instr), w);
    send(vecs[8].instr, 5'd10, ref_dec(vecs[8].instr), w);
    @(negedge clk);
    chk("two_in_ready", 64'(in_ready_a), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; in_instr = vecs[10].instr; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_low", 64'(in_ready_a), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid_a), 64'd0);
    chk("midrst_count", 64'(out_count_a), 64'd0);
    chk("midrst_in_ready", 64'(in_ready_a), 64'd1);
    chk("midrst_out_tag", 64'(out_tag_a), 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("no_stale_entry", 64'(out_valid_a), 64'd0);

    // random traffic with random backpressure
    @(posedge clk); #1;
    rnd_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      r = $urandom();
      in_instr = {r[31:7], ops[$urandom_range(0, 9)]};
      if (in_instr[6:0] == 7'h00) in_instr[6:0] = r[6:0];
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(in_instr, TAG_W'($urandom_range(0, 31)), ref_dec(in_instr), w);
    end
    rnd_mode = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
